// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: deserialises an already-synchronous rx line into bytes on a valid/ready port.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each bit centre.
module uart_rx_deser #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_PT     = HALF_BIT;
`else
    localparam int START_PT     = HALF_BIT - 1;
`endif
    localparam logic [CW-1:0] START_CNT = CW'(START_PT);
    localparam logic [CW-1:0] BIT_CNT   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          armed_q, armed_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          sample_bit;
    logic          at_stop;
    logic          commit;
    logic          stop_bad;

`ifdef UART_RX_MAJORITY_EN
    // Two-deep line history: at decision time it holds the nominal centre and the cycle before it.
    logic [1:0] rx_hist_q, rx_hist_d;

    always_comb begin
        rx_hist_d  = {rx_hist_q[0], uart_rx};
        sample_bit = (uart_rx & rx_hist_q[0]) | (uart_rx & rx_hist_q[1]) | (rx_hist_q[0] & rx_hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_hist_q <= 2'b11;
        end else begin
            rx_hist_q <= rx_hist_d;
        end
    end
`else
    always_comb begin
        sample_bit = uart_rx;
    end
`endif

    // State register and output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            armed_q     <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic. The counter already reads 1 in the first START cycle, so in START cnt equals
    // the number of cycles since the falling edge was seen in IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        armed_d   = armed_q | uart_rx;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (armed_q && !uart_rx) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                end
            end
            START: begin
                if (cnt_q == START_CNT) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = sample_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_CNT) begin
                    cnt_d     = '0;
                    shift_d   = {sample_bit, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_CNT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: stop-bit decision and the byte/valid/pulse updates that follow from it.
    always_comb begin
        busy        = (state_q != IDLE);
        at_stop     = (state_q == STOP) && (cnt_q == BIT_CNT);
        commit      = at_stop && sample_bit;
        stop_bad    = at_stop && !sample_bit;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = stop_bad;
        if (commit) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q && !rx_ready;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: scoreboard of expected bytes checked at each handshake.
module tb_uart_rx_deser;

`ifdef UART_RX_MAJORITY_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_rise_cyc = -1;
    int valid_fall_cyc = -1;
    int valid_rise_cnt = 0;
    int ferr_cnt = 0;
    int ferr_cyc = -1;
    int ovr_cnt = 0;
    int ovr_cyc = -1;
    logic valid_prev = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_deser #(.CLK_FREQ(100000000), .BAUD(500000)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops on handshake, overrun drops the overwritten byte.
    always @(negedge clk) begin
        if (rx_valid && !valid_prev) begin
            valid_rise_cyc = cyc;
            valid_rise_cnt++;
        end
        if (!rx_valid && valid_prev) valid_fall_cyc = cyc;
        valid_prev = rx_valid;
        if (frame_err) begin
            ferr_cnt++;
            ferr_cyc = cyc;
            $display("frame_err pulse at cycle %0d", cyc);
        end
        if (overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
            $display("overrun pulse at cycle %0d", cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (rx_valid && rx_ready) begin
            $display("rx byte %02h accepted at cycle %0d", rx_data, cyc);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_byte", 32'(rx_data), 32'hxxxx_xxxx);
            end else begin
                check("sb_rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1 uart_rx = 1'b1;
        end
    endtask

    // Drives the first nt bit-cycles of a frame; cycle t=0 is the start-edge cycle.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit glitch, input int nt);
        logic [7:0] byte_v;
        logic v;
        int idx;
        byte_v = b;
        for (int t = 0; t < nt; t++) begin
            @(posedge clk);
            #1;
            if (t == 0) start_cyc = cyc;
            if (t < 200) begin
                v = 1'b0;
            end else if (t < 1800) begin
                idx = (t - 200) / 200;
                v = byte_v[idx];
                if (glitch && t == 99 + 200 * (idx + 1)) v = 1'b0;
            end else begin
                v = stop_ok || (t >= 1900);
            end
            uart_rx = v;
        end
    endtask

    initial begin
        int f0;
        int v0;
        rst = 1'b0;
        uart_rx = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_pulses", 32'({frame_err, overrun}), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(20);

        // Single byte, consumer always ready.
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 2000);
        check("a5_valid_rise", 32'(valid_rise_cyc), 32'(start_cyc + 1900 + M));
        check("a5_valid_width", 32'(valid_fall_cyc - valid_rise_cyc), 32'd1);
        check("a5_no_errs", 32'(ferr_cnt + ovr_cnt), 32'd0);
        idle(20);

        // Back-to-back frames with the consumer stalled: second commit overruns.
        rx_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 2000);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0, 2000);
        idle(5);
        @(negedge clk);
        check("ovr_count", 32'(ovr_cnt), 32'd1);
        check("ovr_cycle", 32'(ovr_cyc), 32'(start_cyc + 1900 + M));
        check("ovr_valid_held", 32'(rx_valid), 32'h1);
        check("ovr_rx_data", 32'(rx_data), 32'hC3);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_valid_cleared", 32'(rx_valid), 32'h0);
        check("ovr_sb_empty", 32'(exp_q.size()), 32'd0);

        // Stop bit low: frame error, byte discarded, next frame fine.
        f0 = ferr_cnt;
        v0 = valid_rise_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 2000);
        check("ferr_count", 32'(ferr_cnt), 32'(f0 + 1));
        check("ferr_cycle", 32'(ferr_cyc), 32'(start_cyc + 1900 + M));
        check("ferr_no_valid", 32'(valid_rise_cnt), 32'(v0));
        idle(20);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0, 2000);
        idle(10);
        check("after_ferr_sb_empty", 32'(exp_q.size()), 32'd0);

        // 50-cycle glitch: false start, no output.
        f0 = ferr_cnt;
        v0 = valid_rise_cnt;
        for (int t = 0; t < 250; t++) begin
            @(posedge clk);
            #1 uart_rx = (t >= 50);
            if (t == 99 + M) begin
                @(negedge clk);
                check("glitch_busy_at_sample", 32'(busy), 32'h1);
            end
            if (t == 100 + M) begin
                @(negedge clk);
                check("glitch_busy_dropped", 32'(busy), 32'h0);
            end
        end
        check("glitch_no_outputs", 32'(valid_rise_cnt + ferr_cnt), 32'(v0 + f0));

        // 1-cycle low glitch at each data-bit centre.
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(8'hFF);
`else
        exp_q.push_back(8'h00);
`endif
        send_frame(8'hFF, 1'b1, 1'b1, 2000);
        idle(10);
        check("centre_glitch_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset at t=900, released with the line low.
        f0 = ferr_cnt;
        send_frame(8'h5A, 1'b1, 1'b0, 900);
        @(posedge clk);
        #1;
        rst = 1'b0;
        uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset_rx_data", 32'(rx_data), 32'h00);
        check("midreset_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("unarmed_busy", 32'(busy), 32'h0);
        idle(50);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0, 2000);
        idle(10);
        check("rearm_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rearm_no_ferr", 32'(ferr_cnt), 32'(f0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
